// File: rtl/muldiv_sequencer_pkg.sv
// Shared types, constants and op-decode helpers for the RV32M multiply/divide unit.
package muldiv_sequencer_pkg;

  localparam int MD_XLEN = 32;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } muldiv_state_e;

  localparam logic [MD_XLEN-1:0] MD_DIV0_QUOT    = '1;
  localparam logic [MD_XLEN-1:0] MD_OVF_DIVIDEND = {1'b1, {(MD_XLEN-1){1'b0}}};

  function automatic logic md_is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic md_is_rem(input muldiv_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic md_signed_a(input muldiv_op_e op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_signed_b(input muldiv_op_e op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step.
// {hi,lo} holds partial product / {remainder,quotient}; opnd is multiplicand / divisor.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN-1:0] addend;
  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   rem_diff;

  always_comb begin
    addend    = lo_i[0] ? opnd_i : '0;
    add_sum   = {1'b0, hi_i} + {1'b0, addend};
    rem_shift = {hi_i, lo_i[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, opnd_i};
    if (div_i) begin
      // Borrow out means the trial subtraction failed: keep the shifted remainder.
      if (rem_diff[XLEN]) begin
        hi_o = rem_shift[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b0};
      end else begin
        hi_o = rem_diff[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b1};
      end
    end else begin
      hi_o = add_sum[XLEN:1];
      lo_o = {add_sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit for the EX stage: FSM, step counter, sign fix-up, handshake.
// Define MULDIV_FAST_MUL_EN to resolve MUL* ops with a single-cycle '*' multiplier.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN           = MD_XLEN,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            req_valid,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            req_ready,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy_stall
);

  localparam int STEPS = XLEN / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0] COUNT_INIT = CW'(STEPS);

  generate
    if (!((BITS_PER_CYCLE == 1) || (BITS_PER_CYCLE == 2)) || (XLEN % BITS_PER_CYCLE != 0)) begin : g_bad_bpc
      $error("muldiv_sequencer: BITS_PER_CYCLE must be 1 or 2 and divide XLEN");
    end
    if (XLEN != MD_XLEN) begin : g_bad_xlen
      $error("muldiv_sequencer: XLEN must match MD_XLEN");
    end
  endgenerate

  muldiv_state_e   state_q;
  muldiv_op_e      op_q;
  logic            neg_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] opnd_q;
  logic [XLEN-1:0] resp_data_q;

  muldiv_op_e      req_op_e;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;
  logic            neg_d;
  logic [XLEN-1:0] special_data;
  logic [XLEN-1:0] result_d;
  logic            op_is_div;

  always_comb begin
    req_op_e = muldiv_op_e'(req_op);
    a_neg    = md_signed_a(req_op_e) & req_a[XLEN-1];
    b_neg    = md_signed_b(req_op_e) & req_b[XLEN-1];
    a_mag    = a_neg ? -req_a : req_a;
    b_mag    = b_neg ? -req_b : req_b;
    div_zero = md_is_div(req_op_e) && (req_b == '0);
    div_ovf  = ((req_op_e == MD_DIV) || (req_op_e == MD_REM)) &&
               (req_a == MD_OVF_DIVIDEND) && (req_b == '1);
    // Remainder follows the dividend's sign; everything else follows sign(a) xor sign(b).
    neg_d    = md_is_rem(req_op_e) ? a_neg : (a_neg ^ b_neg);
    count_d  = count_q - CW'(1);
    special_data = '0;
    if (div_zero) begin
      special_data = md_is_rem(req_op_e) ? req_a : MD_DIV0_QUOT;
    end else if (!md_is_rem(req_op_e)) begin
      special_data = MD_OVF_DIVIDEND;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a;
  logic [2*XLEN-1:0] fast_b;
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN-1:0]   fast_data;

  always_comb begin
    fast_a    = {{XLEN{a_neg}}, req_a};
    fast_b    = {{XLEN{b_neg}}, req_b};
    fast_prod = fast_a * fast_b;
    fast_data = (req_op_e == MD_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`endif

  assign op_is_div = md_is_div(op_q);

  logic [XLEN-1:0] hi_chain [BITS_PER_CYCLE+1];
  logic [XLEN-1:0] lo_chain [BITS_PER_CYCLE+1];

  assign hi_chain[0] = hi_q;
  assign lo_chain[0] = lo_q;

  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .div_i  (op_is_div),
      .hi_i   (hi_chain[gi]),
      .lo_i   (lo_chain[gi]),
      .opnd_i (opnd_q),
      .hi_o   (hi_chain[gi+1]),
      .lo_o   (lo_chain[gi+1])
    );
  end

  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_sel;
  logic [XLEN-1:0]   div_fix;

  always_comb begin
    prod     = {hi_chain[BITS_PER_CYCLE], lo_chain[BITS_PER_CYCLE]};
    prod_fix = neg_q ? -prod : prod;
    div_sel  = md_is_rem(op_q) ? hi_chain[BITS_PER_CYCLE] : lo_chain[BITS_PER_CYCLE];
    div_fix  = neg_q ? -div_sel : div_sel;
    if (op_is_div) begin
      result_d = div_fix;
    end else if (op_q == MD_MUL) begin
      result_d = prod_fix[XLEN-1:0];
    end else begin
      result_d = prod_fix[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= MD_IDLE;
      op_q        <= MD_MUL;
      neg_q       <= 1'b0;
      count_q     <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      resp_data_q <= '0;
    end else if (flush) begin
      state_q <= MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (req_valid) begin
            op_q    <= req_op_e;
            neg_q   <= neg_d;
            count_q <= COUNT_INIT;
            hi_q    <= '0;
            lo_q    <= md_is_div(req_op_e) ? a_mag : b_mag;
            opnd_q  <= md_is_div(req_op_e) ? b_mag : a_mag;
            if (div_zero || div_ovf) begin
              resp_data_q <= special_data;
              state_q     <= MD_DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!md_is_div(req_op_e)) begin
              resp_data_q <= fast_data;
              state_q     <= MD_DONE;
            end
`endif
            else begin
              state_q <= MD_BUSY;
            end
          end
        end
        MD_BUSY: begin
          hi_q    <= hi_chain[BITS_PER_CYCLE];
          lo_q    <= lo_chain[BITS_PER_CYCLE];
          count_q <= count_d;
          if (count_q == CW'(1)) begin
            resp_data_q <= result_d;
            state_q     <= MD_DONE;
          end
        end
        MD_DONE: begin
          if (resp_ready) begin
            state_q <= MD_IDLE;
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign req_ready  = reset && (state_q == MD_IDLE) && req_valid && !flush;
  assign resp_valid = (state_q == MD_DONE);
  assign resp_data  = resp_data_q;
  assign busy_stall = reset && (((state_q == MD_IDLE) && req_valid && !flush) ||
                                (state_q == MD_BUSY) ||
                                ((state_q == MD_DONE) && !resp_ready));

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: one task per scenario, one line per transaction.
module tb_muldiv_sequencer;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam int DIV_LAT = 33;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk;
  logic        reset;
  logic        flush;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy_stall;

  int total = 0;
  int bad   = 0;

  muldiv_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy_stall (busy_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one op from IDLE and waits (bounded) for resp_valid; lat=-1 on timeout.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic rdy, output int lat, output logic [31:0] data,
                       output logic stall_ok);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    #1;
    rdy      = req_ready;
    stall_ok = busy_stall;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 100) begin
      stall_ok = stall_ok & busy_stall;
      @(posedge clk); #1;
      lat++;
    end
    if (resp_valid !== 1'b1) lat = -1;
    data = resp_data;
    $display("txn op=%0d a=%h b=%h data=%h latency=%0d", op, a, b, data, lat);
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = 3'b000; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    total++; if (resp_data !== 32'h0) begin bad++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
    total++; if (busy_stall !== 1'b0) begin bad++; $display("FAIL reset_busy_stall: got %b want 0", busy_stall); end
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL post_reset_resp_valid: got %b want 0", resp_valid); end
  endtask

  task automatic test_divu();
    logic rdy, st; int lat; logic [31:0] d;
    issue(OP_DIVU, 32'd100, 32'd7, rdy, lat, d, st);
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL divu_req_ready: got %b want 1", rdy); end
    total++; if (lat != DIV_LAT) begin bad++; $display("FAIL divu_latency: got %0d want %0d", lat, DIV_LAT); end
    total++; if (d !== 32'd14) begin bad++; $display("FAIL divu_data: got %h want %h", d, 32'd14); end
    total++; if (st !== 1'b1) begin bad++; $display("FAIL divu_stall_busy: got %b want 1", st); end
    total++; if (busy_stall !== 1'b1) begin bad++; $display("FAIL divu_stall_done: got %b want 1", busy_stall); end
    resp_ready = 1'b1;
    #1;
    total++; if (busy_stall !== 1'b0) begin bad++; $display("FAIL divu_stall_taken: got %b want 0", busy_stall); end
    @(posedge clk); #1;
    resp_ready = 1'b0;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL divu_resp_drop: got %b want 0", resp_valid); end
  endtask

  task automatic test_rem();
    logic rdy, st; int lat; logic [31:0] d;
    issue(OP_REM, 32'hFFFF_FFF9, 32'd2, rdy, lat, d, st);
    total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rem_neg_data: got %h want %h", d, 32'hFFFF_FFFF); end
    total++; if (lat != DIV_LAT) begin bad++; $display("FAIL rem_neg_latency: got %0d want %0d", lat, DIV_LAT); end
    consume();
    issue(OP_REMU, 32'd7, 32'd0, rdy, lat, d, st);
    total++; if (d !== 32'd7) begin bad++; $display("FAIL remu_div0_data: got %h want %h", d, 32'd7); end
    total++; if (lat != 1) begin bad++; $display("FAIL remu_div0_latency: got %0d want 1", lat); end
    consume();
  endtask

  task automatic test_div_special();
    logic rdy, st; int lat; logic [31:0] d;
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, rdy, lat, d, st);
    total++; if (d !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_data: got %h want %h", d, 32'h8000_0000); end
    total++; if (lat != 1) begin bad++; $display("FAIL div_ovf_latency: got %0d want 1", lat); end
    consume();
    issue(OP_DIV, 32'd5, 32'd0, rdy, lat, d, st);
    total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_zero_data: got %h want %h", d, 32'hFFFF_FFFF); end
    total++; if (lat != 1) begin bad++; $display("FAIL div_zero_latency: got %0d want 1", lat); end
    consume();
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, rdy, lat, d, st);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rem_ovf_data: got %h want 0", d); end
    consume();
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, rdy, lat, d, st);
    total++; if (d !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_neg_data: got %h want %h", d, 32'hFFFF_FFFD); end
    consume();
  endtask

  task automatic test_mul();
    logic rdy, st; int lat; logic [31:0] d;
    issue(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rdy, lat, d, st);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mulh_data: got %h want 0", d); end
    total++; if (lat != MUL_LAT) begin bad++; $display("FAIL mulh_latency: got %0d want %0d", lat, MUL_LAT); end
    consume();
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rdy, lat, d, st);
    total++; if (d !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mulhu_data: got %h want %h", d, 32'hFFFF_FFFE); end
    consume();
    issue(OP_MULHSU, 32'hFFFF_FFFF, 32'd2, rdy, lat, d, st);
    total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mulhsu_data: got %h want %h", d, 32'hFFFF_FFFF); end
    consume();
    issue(OP_MUL, 32'hFFFF_FFFD, 32'd5, rdy, lat, d, st);
    total++; if (d !== 32'hFFFF_FFF1) begin bad++; $display("FAIL mul_data: got %h want %h", d, 32'hFFFF_FFF1); end
    consume();
    issue(OP_MULHU, 32'h8000_0000, 32'd4, rdy, lat, d, st);
    total++; if (d !== 32'd2) begin bad++; $display("FAIL mulhu_small_data: got %h want %h", d, 32'd2); end
    consume();
  endtask

  task automatic test_flush();
    logic rdy, st; int lat; logic [31:0] d; int seen;
    req_op = OP_DIVU; req_a = 32'd1000; req_b = 32'd3; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL flush_busy_resp_valid: got %b want 0", resp_valid); end
    total++; if (busy_stall !== 1'b0) begin bad++; $display("FAIL flush_busy_stall: got %b want 0", busy_stall); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (resp_valid === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL flush_no_resp: got %0d responses want 0", seen); end
    // Flush in IDLE must block acceptance even with a request present.
    req_op = OP_REMU; req_a = 32'd7; req_b = 32'd0; req_valid = 1'b1; flush = 1'b1;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL flush_idle_req_ready: got %b want 0", req_ready); end
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL flush_idle_no_accept: got %b want 0", resp_valid); end
    issue(OP_DIVU, 32'd9, 32'd3, rdy, lat, d, st);
    total++; if (d !== 32'd3) begin bad++; $display("FAIL flush_recover_data: got %h want %h", d, 32'd3); end
    total++; if (lat != DIV_LAT) begin bad++; $display("FAIL flush_recover_latency: got %0d want %0d", lat, DIV_LAT); end
    // Flush while DONE drops the held response.
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL flush_done_resp_valid: got %b want 0", resp_valid); end
  endtask

  task automatic test_hold();
    logic rdy, st; int lat; logic [31:0] d;
    issue(OP_DIVU, 32'd50, 32'd5, rdy, lat, d, st);
    for (int i = 0; i < 5; i++) begin
      total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d]: got %b want 1", i, resp_valid); end
      total++; if (resp_data !== 32'd10) begin bad++; $display("FAIL hold_data[%0d]: got %h want %h", i, resp_data, 32'd10); end
      total++; if (busy_stall !== 1'b1) begin bad++; $display("FAIL hold_stall[%0d]: got %b want 1", i, busy_stall); end
      @(posedge clk); #1;
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic rdy, st; int lat; logic [31:0] d;
    issue(OP_REMU, 32'd7, 32'd0, rdy, lat, d, st);
    resp_ready = 1'b1;
    req_op = OP_DIVU; req_a = 32'd9; req_b = 32'd3; req_valid = 1'b1;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_no_accept_in_done: got %b want 0", req_ready); end
    @(posedge clk); #1;
    resp_ready = 1'b0;
    issue(OP_DIVU, 32'd9, 32'd3, rdy, lat, d, st);
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL b2b_accept_idle: got %b want 1", rdy); end
    total++; if (d !== 32'd3) begin bad++; $display("FAIL b2b_data: got %h want %h", d, 32'd3); end
    consume();
  endtask

  task automatic test_reset_mid();
    int seen;
    req_op = OP_DIVU; req_a = 32'd1000; req_b = 32'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_resp_valid: got %b want 0", resp_valid); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_req_ready: got %b want 0", req_ready); end
    total++; if (resp_data !== 32'h0) begin bad++; $display("FAIL rst_mid_resp_data: got %h want 0", resp_data); end
    total++; if (busy_stall !== 1'b0) begin bad++; $display("FAIL rst_mid_busy_stall: got %b want 0", busy_stall); end
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (resp_valid === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rst_mid_no_resp: got %0d responses want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_rem();
    test_div_special();
    test_mul();
    test_flush();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
